// File: rtl/alu_rs_pkg.sv
// -----------------------------------------------------------------------------
// alu_rs_pkg
// Shared types and widths for the integer-ALU reservation station. It holds
// the core-wide widths (XLEN, ROB id width, ALU opcode width), the ALU opcode
// enum, the operand and entry records, and the broadcast-snoop helper. Both
// dispatch bypass and per-entry wakeup use the same helper.
// -----------------------------------------------------------------------------
package alu_rs_pkg;

    localparam int XLEN              = 32;
    localparam int ROB_SIZE_WIDTH    = 4;
    localparam int ALU_OP_WIDTH      = 4;
    localparam int DEF_RS_SIZE_WIDTH = 3;

    typedef logic [XLEN-1:0]           xlen_t;
    typedef logic [ROB_SIZE_WIDTH-1:0] rob_id_t;

    typedef enum logic [ALU_OP_WIDTH-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    // One source operand. While pending is set, val is stale and tag names
    // the ROB entry that will produce it.
    typedef struct packed {
        logic    pending;
        rob_id_t tag;
        xlen_t   val;
    } operand_t;

    typedef struct packed {
        logic     busy;
        alu_op_e  op;
        rob_id_t  id;
        operand_t src1;
        operand_t src2;
    } rs_entry_t;

    // Resolve a pending operand against this cycle's result broadcasts. The
    // ALU bus is checked first; the two buses never carry the same id.
    function automatic operand_t snoop(
        input operand_t opnd,
        input logic     alu_ready,
        input rob_id_t  alu_id,
        input xlen_t    alu_res,
        input logic     lsb_ready,
        input rob_id_t  lsb_id,
        input xlen_t    lsb_res
    );
        operand_t r;
        r = opnd;
        if (opnd.pending) begin
            if (alu_ready && (opnd.tag == alu_id)) begin
                r.pending = 1'b0;
                r.val     = alu_res;
            end else if (lsb_ready && (opnd.tag == lsb_id)) begin
                r.pending = 1'b0;
                r.val     = lsb_res;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_rs_if.sv
// -----------------------------------------------------------------------------
// alu_rs_if
// Signal bundle around the ALU reservation station:
//   flush                        mispredict flush from the ROB
//   dec_*                        dispatch request from decode
//   alu_* / lsb_*                result broadcasts (ALU and load buffer)
//   rs_full                      all entries occupied
//   rs_ready/op/val1/val2/id     registered issue bus to the ALU
// The master modport is the surrounding core (or bench); slave is alu_rs.
// -----------------------------------------------------------------------------
interface alu_rs_if;
    import alu_rs_pkg::*;

    logic    flush;

    logic    dec_valid;
    alu_op_e dec_op;
    rob_id_t dec_id;
    xlen_t   dec_val1;
    xlen_t   dec_val2;
    logic    dec_q1_valid;
    logic    dec_q2_valid;
    rob_id_t dec_q1;
    rob_id_t dec_q2;

    logic    alu_ready;
    xlen_t   alu_res;
    rob_id_t alu_id;

    logic    lsb_ready;
    xlen_t   lsb_res;
    rob_id_t lsb_id;

    logic    rs_full;
    logic    rs_ready;
    alu_op_e rs_op;
    xlen_t   rs_val1;
    xlen_t   rs_val2;
    rob_id_t rs_id;

    modport master (
        output flush,
        output dec_valid, dec_op, dec_id, dec_val1, dec_val2,
        output dec_q1_valid, dec_q2_valid, dec_q1, dec_q2,
        output alu_ready, alu_res, alu_id,
        output lsb_ready, lsb_res, lsb_id,
        input  rs_full, rs_ready, rs_op, rs_val1, rs_val2, rs_id
    );

    modport slave (
        input  flush,
        input  dec_valid, dec_op, dec_id, dec_val1, dec_val2,
        input  dec_q1_valid, dec_q2_valid, dec_q1, dec_q2,
        input  alu_ready, alu_res, alu_id,
        input  lsb_ready, lsb_res, lsb_id,
        output rs_full, rs_ready, rs_op, rs_val1, rs_val2, rs_id
    );

endinterface

// File: rtl/rs_prio_enc.sv
// -----------------------------------------------------------------------------
// rs_prio_enc
// Lowest-index-set-bit priority encoder.
//   req_i   [WIDTH]  request vector
//   idx_o   [IDX_W]  index of the lowest set bit (0 when none set)
//   found_o          at least one request bit set
// -----------------------------------------------------------------------------
module rs_prio_enc #(
    parameter int WIDTH = 8,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    // NOTE: always_comb assigns every output a default before any branch so no
    // path leaves a value held, which would infer a latch.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        // Scan from the top so the lowest set bit is the last one written.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = IDX_W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// -----------------------------------------------------------------------------
// alu_rs
// Reservation station for the integer ALU. It buffers up to 2^RS_SIZE_WIDTH
// dispatched instructions and snoops the ALU/LSB result broadcasts for pending
// operands. Each cycle it issues the lowest-index operand-complete entry on a
// registered bus.
//   clk    system clock
//   rst_n  synchronous active-low reset
//   bus    alu_rs_if slave: flush, dispatch, broadcasts, rs_full, issue bus
// -----------------------------------------------------------------------------
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int RS_SIZE_WIDTH = DEF_RS_SIZE_WIDTH
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_rs_if.slave  bus
);

    localparam int RS_SIZE = 1 << RS_SIZE_WIDTH;

    rs_entry_t entries_q [RS_SIZE];
    rs_entry_t entries_d [RS_SIZE];

    logic    rs_ready_q, rs_ready_d;
    alu_op_e rs_op_q,    rs_op_d;
    xlen_t   rs_val1_q,  rs_val1_d;
    xlen_t   rs_val2_q,  rs_val2_d;
    rob_id_t rs_id_q,    rs_id_d;

    logic [RS_SIZE-1:0]       busy_vec, ready_vec, alloc_oh, issue_oh;
    logic [RS_SIZE_WIDTH-1:0] free_idx, sel_idx;
    logic                     free_found, sel_found;
    rs_entry_t                new_entry;

    // Status vectors come from registered state only. An entry woken this
    // cycle is therefore not selectable until the next one.
    always_comb begin
        busy_vec  = '0;
        ready_vec = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            busy_vec[i]  = entries_q[i].busy;
            ready_vec[i] = entries_q[i].busy && !entries_q[i].src1.pending
                                             && !entries_q[i].src2.pending;
        end
    end

    rs_prio_enc #(.WIDTH(RS_SIZE), .IDX_W(RS_SIZE_WIDTH)) u_free_enc (
        .req_i   (~busy_vec),
        .idx_o   (free_idx),
        .found_o (free_found)
    );

    rs_prio_enc #(.WIDTH(RS_SIZE), .IDX_W(RS_SIZE_WIDTH)) u_sel_enc (
        .req_i   (ready_vec),
        .idx_o   (sel_idx),
        .found_o (sel_found)
    );

    // A slot freed by this cycle's issue is still busy in registered state,
    // so the free search cannot hand it out until the next cycle.
    assign bus.rs_full = &busy_vec;
    assign alloc_oh    = (bus.dec_valid && free_found) ? (RS_SIZE'(1) << free_idx) : '0;
    assign issue_oh    = sel_found ? (RS_SIZE'(1) << sel_idx) : '0;

    // Incoming entry, with its operands resolved against same-cycle broadcasts.
    always_comb begin
        new_entry      = '0;
        new_entry.busy = 1'b1;
        new_entry.op   = bus.dec_op;
        new_entry.id   = bus.dec_id;
        new_entry.src1 = snoop('{pending: bus.dec_q1_valid, tag: bus.dec_q1, val: bus.dec_val1},
                               bus.alu_ready, bus.alu_id, bus.alu_res,
                               bus.lsb_ready, bus.lsb_id, bus.lsb_res);
        new_entry.src2 = snoop('{pending: bus.dec_q2_valid, tag: bus.dec_q2, val: bus.dec_val2},
                               bus.alu_ready, bus.alu_id, bus.alu_res,
                               bus.lsb_ready, bus.lsb_id, bus.lsb_res);
    end

    // NOTE: combinational next-state logic uses blocking '=' so later lines
    // see earlier updates; registers below take them with '<='.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            entries_d[i] = entries_q[i];
            if (entries_q[i].busy) begin
                entries_d[i].src1 = snoop(entries_q[i].src1,
                                          bus.alu_ready, bus.alu_id, bus.alu_res,
                                          bus.lsb_ready, bus.lsb_id, bus.lsb_res);
                entries_d[i].src2 = snoop(entries_q[i].src2,
                                          bus.alu_ready, bus.alu_id, bus.alu_res,
                                          bus.lsb_ready, bus.lsb_id, bus.lsb_res);
            end
            if (issue_oh[i]) entries_d[i].busy = 1'b0;
            if (alloc_oh[i]) entries_d[i]      = new_entry;
        end
    end

    always_comb begin
        rs_ready_d = sel_found;
        rs_op_d    = ALU_ADD;
        rs_val1_d  = '0;
        rs_val2_d  = '0;
        rs_id_d    = '0;
        if (sel_found) begin
            rs_op_d   = entries_q[sel_idx].op;
            rs_val1_d = entries_q[sel_idx].src1.val;
            rs_val2_d = entries_q[sel_idx].src2.val;
            rs_id_d   = entries_q[sel_idx].id;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush) begin
            // NOTE: only the busy bits are cleared; payload fields are don't-care
            // while an entry is free and are rewritten whole on allocation.
            for (int i = 0; i < RS_SIZE; i++) entries_q[i].busy <= 1'b0;
            rs_ready_q <= 1'b0;
            rs_op_q    <= ALU_ADD;
            rs_val1_q  <= '0;
            rs_val2_q  <= '0;
            rs_id_q    <= '0;
        end else begin
            entries_q  <= entries_d;
            rs_ready_q <= rs_ready_d;
            rs_op_q    <= rs_op_d;
            rs_val1_q  <= rs_val1_d;
            rs_val2_q  <= rs_val2_d;
            rs_id_q    <= rs_id_d;
        end
    end

    assign bus.rs_ready = rs_ready_q;
    assign bus.rs_op    = rs_op_q;
    assign bus.rs_val1  = rs_val1_q;
    assign bus.rs_val2  = rs_val2_q;
    assign bus.rs_id    = rs_id_q;

endmodule

// File: tb/tb_alu_rs.sv
// -----------------------------------------------------------------------------
// tb_alu_rs
// Directed-vector bench for alu_rs. Inputs change on the falling edge and
// outputs are sampled there as well, half a cycle after the rising edge that
// produced them. The issue bus is compared as one packed word
// {rs_ready, rs_op, rs_id, rs_val1, rs_val2}.
// -----------------------------------------------------------------------------
module tb_alu_rs;
    import alu_rs_pkg::*;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    alu_rs_if bus();

    alu_rs #(.RS_SIZE_WIDTH(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [72:0] IDLE_BUS = '0;

    function automatic logic [72:0] issue_bus();
        return {bus.rs_ready, bus.rs_op, bus.rs_id, bus.rs_val1, bus.rs_val2};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.flush        = 1'b0;
        bus.dec_valid    = 1'b0;
        bus.dec_op       = ALU_ADD;
        bus.dec_id       = '0;
        bus.dec_val1     = '0;
        bus.dec_val2     = '0;
        bus.dec_q1_valid = 1'b0;
        bus.dec_q2_valid = 1'b0;
        bus.dec_q1       = '0;
        bus.dec_q2       = '0;
        bus.alu_ready    = 1'b0;
        bus.alu_res      = '0;
        bus.alu_id       = '0;
        bus.lsb_ready    = 1'b0;
        bus.lsb_res      = '0;
        bus.lsb_id       = '0;
    endtask

    task automatic dispatch(input alu_op_e op, input rob_id_t id,
                            input xlen_t v1, input logic q1v, input rob_id_t q1,
                            input xlen_t v2, input logic q2v, input rob_id_t q2);
        bus.dec_valid    = 1'b1;
        bus.dec_op       = op;
        bus.dec_id       = id;
        bus.dec_val1     = v1;
        bus.dec_q1_valid = q1v;
        bus.dec_q1       = q1;
        bus.dec_val2     = v2;
        bus.dec_q2_valid = q2v;
        bus.dec_q2       = q2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
        vectors++;
        if ({issue_bus(), bus.rs_full} !== {IDLE_BUS, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state: got %h/%b expected %h/0", issue_bus(), bus.rs_full, IDLE_BUS);
        end
        tick();
        vectors++;
        if (issue_bus() !== IDLE_BUS) begin
            miscompares++;
            $display("FAIL reset_idle: got %h expected %h", issue_bus(), IDLE_BUS);
        end
    endtask

    task automatic test_ready_dispatch();
        dispatch(ALU_ADD, 4'd3, 32'd5, 1'b0, 4'd0, 32'd7, 1'b0, 4'd0);
        tick();
        clear_inputs();
        vectors++;
        if (bus.rs_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_dispatch_latency: rs_ready got %b expected 0", bus.rs_ready);
        end
        tick();
        vectors++;
        if (issue_bus() !== {1'b1, ALU_ADD, 4'd3, 32'd5, 32'd7}) begin
            miscompares++;
            $display("FAIL ready_dispatch_issue: got %h expected %h", issue_bus(),
                     {1'b1, ALU_ADD, 4'd3, 32'd5, 32'd7});
        end
        tick();
        vectors++;
        if (issue_bus() !== IDLE_BUS) begin
            miscompares++;
            $display("FAIL ready_dispatch_drain: got %h expected %h", issue_bus(), IDLE_BUS);
        end
    endtask

    task automatic test_wakeup();
        dispatch(ALU_SUB, 4'd1, 32'hBAD, 1'b1, 4'd6, 32'd2, 1'b0, 4'd0);
        tick();
        clear_inputs();
        // Hold four cycles; one carries a broadcast for an unrelated tag.
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (bus.rs_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL wakeup_hold%0d: rs_ready got %b expected 0", k, bus.rs_ready);
            end
            bus.alu_ready = (k == 1);
            bus.alu_id    = 4'd7;
            bus.alu_res   = 32'h77;
            tick();
        end
        bus.alu_ready = 1'b1;
        bus.alu_id    = 4'd6;
        bus.alu_res   = 32'h10;
        tick();
        clear_inputs();
        vectors++;
        if (bus.rs_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL wakeup_same_cycle: rs_ready got %b expected 0", bus.rs_ready);
        end
        tick();
        vectors++;
        if (issue_bus() !== {1'b1, ALU_SUB, 4'd1, 32'h10, 32'd2}) begin
            miscompares++;
            $display("FAIL wakeup_issue: got %h expected %h", issue_bus(),
                     {1'b1, ALU_SUB, 4'd1, 32'h10, 32'd2});
        end
        tick();
    endtask

    task automatic test_bypass();
        // LSB bypass on src2; a non-matching ALU broadcast is present as well.
        dispatch(ALU_XOR, 4'd5, 32'd3, 1'b0, 4'd0, 32'hBAD, 1'b1, 4'd4);
        bus.lsb_ready = 1'b1;
        bus.lsb_id    = 4'd4;
        bus.lsb_res   = 32'hFF;
        bus.alu_ready = 1'b1;
        bus.alu_id    = 4'd2;
        bus.alu_res   = 32'h22;
        tick();
        clear_inputs();
        vectors++;
        if (bus.rs_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bypass_latency: rs_ready got %b expected 0", bus.rs_ready);
        end
        tick();
        vectors++;
        if (issue_bus() !== {1'b1, ALU_XOR, 4'd5, 32'd3, 32'hFF}) begin
            miscompares++;
            $display("FAIL bypass_issue: got %h expected %h", issue_bus(),
                     {1'b1, ALU_XOR, 4'd5, 32'd3, 32'hFF});
        end
        tick();
        // ALU bypass on src1, src2 woken later by the LSB bus.
        dispatch(ALU_SRL, 4'd7, 32'hDEAD, 1'b1, 4'd10, 32'hBEEF, 1'b1, 4'd11);
        bus.alu_ready = 1'b1;
        bus.alu_id    = 4'd10;
        bus.alu_res   = 32'hA;
        tick();
        clear_inputs();
        tick();
        vectors++;
        if (bus.rs_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bypass_partial: rs_ready got %b expected 0", bus.rs_ready);
        end
        bus.lsb_ready = 1'b1;
        bus.lsb_id    = 4'd11;
        bus.lsb_res   = 32'hB;
        tick();
        clear_inputs();
        tick();
        vectors++;
        if (issue_bus() !== {1'b1, ALU_SRL, 4'd7, 32'hA, 32'hB}) begin
            miscompares++;
            $display("FAIL bypass_then_wake: got %h expected %h", issue_bus(),
                     {1'b1, ALU_SRL, 4'd7, 32'hA, 32'hB});
        end
        tick();
    endtask

    task automatic test_back_to_back();
        dispatch(ALU_OR, 4'd2, 32'h20, 1'b0, 4'd0, 32'h21, 1'b0, 4'd0);
        tick();
        vectors++;
        if (bus.rs_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_first: rs_ready got %b expected 0", bus.rs_ready);
        end
        dispatch(ALU_AND, 4'd3, 32'h30, 1'b0, 4'd0, 32'h31, 1'b0, 4'd0);
        tick();
        vectors++;
        if (issue_bus() !== {1'b1, ALU_OR, 4'd2, 32'h20, 32'h21}) begin
            miscompares++;
            $display("FAIL b2b_issue0: got %h expected %h", issue_bus(),
                     {1'b1, ALU_OR, 4'd2, 32'h20, 32'h21});
        end
        dispatch(ALU_SLL, 4'd4, 32'h40, 1'b0, 4'd0, 32'h41, 1'b0, 4'd0);
        tick();
        clear_inputs();
        vectors++;
        if (issue_bus() !== {1'b1, ALU_AND, 4'd3, 32'h30, 32'h31}) begin
            miscompares++;
            $display("FAIL b2b_issue1: got %h expected %h", issue_bus(),
                     {1'b1, ALU_AND, 4'd3, 32'h30, 32'h31});
        end
        tick();
        vectors++;
        if (issue_bus() !== {1'b1, ALU_SLL, 4'd4, 32'h40, 32'h41}) begin
            miscompares++;
            $display("FAIL b2b_issue2: got %h expected %h", issue_bus(),
                     {1'b1, ALU_SLL, 4'd4, 32'h40, 32'h41});
        end
        tick();
        vectors++;
        if (issue_bus() !== IDLE_BUS) begin
            miscompares++;
            $display("FAIL b2b_drain: got %h expected %h", issue_bus(), IDLE_BUS);
        end
    endtask

    task automatic test_full_order();
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                vectors++;
                if (bus.rs_full !== 1'b0) begin
                    miscompares++;
                    $display("FAIL full_at_7: rs_full got %b expected 0", bus.rs_full);
                end
            end
            dispatch(ALU_ADD, 4'(i), 32'hBAD, 1'b1, 4'd9, 32'(i), 1'b0, 4'd0);
            tick();
        end
        clear_inputs();
        vectors++;
        if ({bus.rs_full, bus.rs_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL full_at_8: full/ready got %b%b expected 10", bus.rs_full, bus.rs_ready);
        end
        // Ready-operand dispatch into a full station must be dropped.
        dispatch(ALU_SUB, 4'd15, 32'hE, 1'b0, 4'd0, 32'hF, 1'b0, 4'd0);
        tick();
        clear_inputs();
        vectors++;
        if ({bus.rs_full, bus.rs_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL full_ignore: full/ready got %b%b expected 10", bus.rs_full, bus.rs_ready);
        end
        bus.alu_ready = 1'b1;
        bus.alu_id    = 4'd9;
        bus.alu_res   = 32'h99;
        tick();
        clear_inputs();
        vectors++;
        if ({bus.rs_full, bus.rs_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL full_woken: full/ready got %b%b expected 10", bus.rs_full, bus.rs_ready);
        end
        // Still full at this edge even though an issue happens in it.
        dispatch(ALU_SUB, 4'd14, 32'hC, 1'b0, 4'd0, 32'hD, 1'b0, 4'd0);
        tick();
        clear_inputs();
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (issue_bus() !== {1'b1, ALU_ADD, 4'(k), 32'h99, 32'(k)}) begin
                miscompares++;
                $display("FAIL order_issue%0d: got %h expected %h", k, issue_bus(),
                         {1'b1, ALU_ADD, 4'(k), 32'h99, 32'(k)});
            end
            if (k == 0) begin
                vectors++;
                if (bus.rs_full !== 1'b0) begin
                    miscompares++;
                    $display("FAIL full_drop: rs_full got %b expected 0", bus.rs_full);
                end
            end
            tick();
        end
        vectors++;
        if (issue_bus() !== IDLE_BUS) begin
            miscompares++;
            $display("FAIL order_drain: got %h expected %h", issue_bus(), IDLE_BUS);
        end
    endtask

    task automatic test_clear(input bit use_reset);
        for (int i = 0; i < 3; i++) begin
            dispatch(ALU_ADD, 4'(i + 1), 32'hBAD, 1'b1, 4'd12, 32'(8'h50 + i), 1'b0, 4'd0);
            tick();
        end
        clear_inputs();
        bus.alu_ready = 1'b1;
        bus.alu_id    = 4'd12;
        bus.alu_res   = 32'h12;
        tick();
        clear_inputs();
        tick();
        vectors++;
        if (issue_bus() !== {1'b1, ALU_ADD, 4'd1, 32'h12, 32'h50}) begin
            miscompares++;
            $display("FAIL clear%0d_pre_issue: got %h expected %h", use_reset, issue_bus(),
                     {1'b1, ALU_ADD, 4'd1, 32'h12, 32'h50});
        end
        if (use_reset) rst_n = 1'b0;
        else           bus.flush = 1'b1;
        tick();
        rst_n     = 1'b1;
        bus.flush = 1'b0;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if ({issue_bus(), bus.rs_full} !== {IDLE_BUS, 1'b0}) begin
                miscompares++;
                $display("FAIL clear%0d_after%0d: got %h/%b expected %h/0", use_reset, k,
                         issue_bus(), bus.rs_full, IDLE_BUS);
            end
            tick();
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_ready_dispatch();
        test_wakeup();
        test_bypass();
        test_back_to_back();
        test_full_order();
        test_clear(1'b0);
        test_clear(1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

endmodule
